// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Double-buffered display value, leading-zero blanking and a per-slot anode-off gap.
module led_scan_ctrl #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYC     = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic [3:0]              hex,
   output logic                    dp,
   output logic                    seg_en,
   output logic                    frame_tick,
   output logic                    pending
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      S_GAP = 1'b0,
      S_ON  = 1'b1
   } state_t;

   localparam state_t STATE_RST = (GAP_CYC > 0) ? S_GAP : S_ON;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   state_t                  state_q, state_d;

   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [4*NUM_DIGITS-1:0] display_val_q, display_val_d;
   logic [NUM_DIGITS-1:0]   display_dp_q, display_dp_d;
   logic                    pending_q, pending_d;

   logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic [3:0]              hex_q, hex_d;
   logic                    dp_q, dp_d;
   logic                    seg_en_q, seg_en_d;
   logic                    frame_tick_q, frame_tick_d;

   logic                    slot_wrap;
   logic                    frame_wrap;
   logic [3:0]              nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   blank_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
         assign nib[gi] = display_val_q[4*gi +: 4];
      end
   endgenerate

   // Slot / digit counters
   always_comb begin
      slot_wrap  = (cnt_q == CNT_LAST);
      frame_wrap = slot_wrap && (idx_q == IDX_LAST);
      cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      if (slot_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // State register tracks whether the current cnt lies inside the gap
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= STATE_RST;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = (cnt_d < GAP_END) ? S_GAP : S_ON;
   end

   // Shadow and display buffers; the swap happens only at the frame boundary
   always_comb begin
      shadow_val_d  = shadow_val_q;
      shadow_dp_d   = shadow_dp_q;
      display_val_d = display_val_q;
      display_dp_d  = display_dp_q;
      pending_d     = pending_q;
      frame_tick_d  = frame_wrap;
      if (frame_wrap && pending_q) begin
         display_val_d = shadow_val_q;
         display_dp_d  = shadow_dp_q;
         pending_d     = 1'b0;
      end
      if (load) begin
         shadow_val_d = value_in;
         shadow_dp_d  = dp_in;
         pending_d    = 1'b1;
      end
   end

   // A digit is blank when no nonzero nibble exists at or above it
   always_comb begin
      logic nz_above;
      nz_above  = 1'b0;
      blank_vec = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz_above = nz_above | (|nib[i]);
         if (i != 0) begin
            blank_vec[i] = blank_lz & ~nz_above;
         end
      end
   end

   // Output decode from current state and digit index
   always_comb begin
      digit_en_d = '1;
      hex_d      = 4'h0;
      dp_d       = 1'b1;
      seg_en_d   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            hex_d = nib[i];
            dp_d  = ~display_dp_q[i];
            if (state_q == S_ON) begin
               digit_en_d[i] = 1'b0;
               seg_en_d      = ~blank_vec[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         shadow_val_q  <= '0;
         shadow_dp_q   <= '0;
         display_val_q <= '0;
         display_dp_q  <= '0;
         pending_q     <= 1'b0;
         digit_en_q    <= '1;
         hex_q         <= 4'h0;
         dp_q          <= 1'b1;
         seg_en_q      <= 1'b0;
         frame_tick_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_val_q  <= shadow_val_d;
         shadow_dp_q   <= shadow_dp_d;
         display_val_q <= display_val_d;
         display_dp_q  <= display_dp_d;
         pending_q     <= pending_d;
         digit_en_q    <= digit_en_d;
         hex_q         <= hex_d;
         dp_q          <= dp_d;
         seg_en_q      <= seg_en_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign digit_en   = digit_en_q;
   assign hex        = hex_q;
   assign dp         = dp_q;
   assign seg_en     = seg_en_q;
   assign frame_tick = frame_tick_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl: a cycle-count reference model predicts each
// registered output set, a negedge monitor pops and compares.
module tb_led_scan_ctrl;

   localparam int N = 4;
   localparam int R = 4;
   localparam int G = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0;
   logic [4*N-1:0] value_in = '0;
   logic [N-1:0]  dp_in = '0;
   logic          blank_lz = 1'b0;
   logic [N-1:0]  digit_en;
   logic [3:0]    hex;
   logic          dp;
   logic          seg_en;
   logic          frame_tick;
   logic          pending;

   led_scan_ctrl #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(R),
      .GAP_CYC    (G)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .value_in  (value_in),
      .dp_in     (dp_in),
      .blank_lz  (blank_lz),
      .digit_en  (digit_en),
      .hex       (hex),
      .dp        (dp),
      .seg_en    (seg_en),
      .frame_tick(frame_tick),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] den;
      logic [3:0]   hex;
      logic         dp;
      logic         seg;
      logic         ft;
      logic         pend;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   // Reference model state: time since reset plus the two value buffers
   int             t = 0;
   logic [4*N-1:0] m_shadow_v = '0;
   logic [N-1:0]   m_shadow_dp = '0;
   logic [4*N-1:0] m_disp_v = '0;
   logic [N-1:0]   m_disp_dp = '0;
   bit             m_pend = 1'b0;

   function automatic logic [3:0] nib_of(logic [4*N-1:0] v, int k);
      return v[4*k +: 4];
   endfunction

   initial begin
      forever begin
         exp_t e;
         int   cnt;
         int   idx;
         int   hi;
         bit   swap;
         bit   pend_new;
         @(posedge clk);
         if (reset) begin
            e.den  = '1;
            e.hex  = 4'h0;
            e.dp   = 1'b1;
            e.seg  = 1'b0;
            e.ft   = 1'b0;
            e.pend = 1'b0;
            t = 0;
            m_shadow_v = '0;
            m_shadow_dp = '0;
            m_disp_v = '0;
            m_disp_dp = '0;
            m_pend = 1'b0;
         end else begin
            cnt = t % R;
            idx = (t / R) % N;
            hi = -1;
            for (int k = 0; k < N; k++) begin
               if (nib_of(m_disp_v, k) != 4'h0) hi = k;
            end
            e.hex = nib_of(m_disp_v, idx);
            e.dp  = ~m_disp_dp[idx];
            if (cnt < G) begin
               e.den = '1;
               e.seg = 1'b0;
            end else begin
               e.den = ~(N'(1) << idx);
               e.seg = !(blank_lz && idx != 0 && idx > hi);
            end
            swap = (cnt == R - 1) && (idx == N - 1);
            pend_new = load ? 1'b1 : (swap ? 1'b0 : m_pend);
            e.ft = swap;
            e.pend = pend_new;
            if (swap && m_pend) begin
               m_disp_v = m_shadow_v;
               m_disp_dp = m_shadow_dp;
            end
            if (load) begin
               m_shadow_v = value_in;
               m_shadow_dp = dp_in;
            end
            m_pend = pend_new;
            t++;
         end
         sb.push_back(e);
      end
   end

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   initial begin
      @(posedge clk);
      forever begin
         exp_t e;
         @(negedge clk);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty at %0t: got 0 entries expected 1", $time);
         end else begin
            e = sb.pop_front();
            chk("digit_en", 8'(digit_en), 8'(e.den));
            chk("hex", 8'(hex), 8'(e.hex));
            chk("dp", 8'(dp), 8'(e.dp));
            chk("seg_en", 8'(seg_en), 8'(e.seg));
            chk("frame_tick", 8'(frame_tick), 8'(e.ft));
            chk("pending", 8'(pending), 8'(e.pend));
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(logic [4*N-1:0] v, logic [N-1:0] d);
      load = 1'b1;
      value_in = v;
      dp_in = d;
      $display("load value=%h dp=%b blank_lz=%0d slot=%0d cnt=%0d", v, d, blank_lz,
               (t / R) % N, t % R);
      @(negedge clk);
      load = 1'b0;
   endtask

   // Next posedge will see the counters at (c, i)
   task automatic wait_pos(int c, int i);
      int k;
      k = 0;
      while (!((t % R) == c && ((t / R) % N) == i) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) begin
         total++;
         bad++;
         $display("FAIL wait_pos timeout: got no slot match expected cnt=%0d idx=%0d", c, i);
      end
   endtask

   initial begin
      logic [4*N-1:0] v;
      logic [N-1:0]   d;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      cyc(40);

      wait_pos(0, 1);
      do_load(16'h1234, 4'b0010);
      cyc(48);

      blank_lz = 1'b1;
      do_load(16'h00A0, 4'b0000);
      cyc(32);
      do_load(16'h0000, 4'b0000);
      cyc(32);
      blank_lz = 1'b0;
      cyc(20);

      do_load(16'($urandom), 4'($urandom));
      wait_pos(R - 1, N - 1);
      do_load(16'($urandom), 4'($urandom));
      cyc(48);

      wait_pos(0, 0);
      do_load(16'hBEEF, 4'b1001);
      wait_pos(2, 2);
      reset = 1'b1;
      $display("reset mid-scan at slot=2 cnt=2 pending=%0d", m_pend);
      @(negedge clk);
      reset = 1'b0;
      cyc(20);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            $display("random reset at t=%0d", t);
            @(negedge clk);
            reset = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            v = 16'($urandom);
            d = 4'($urandom);
            if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 4));
            do_load(v, d);
         end else begin
            @(negedge clk);
         end
      end

      cyc(2);
      #1;
      chk("sb_drain", 8'(sb.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1, "watchdog");
   end

endmodule
